// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding, PC/immediate select and
// load-use hazard detection for the 32-bit integer ALU.
module id_ex_operand_stage #(
    parameter int XLEN    = 32,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 6
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               ID_VALID,
    input  logic [XLEN-1:0]    ID_PC,
    input  logic [REG_AW-1:0]  ID_RS1_ADDR,
    input  logic [REG_AW-1:0]  ID_RS2_ADDR,
    input  logic               ID_USES_RS1,
    input  logic               ID_USES_RS2,
    input  logic [XLEN-1:0]    ID_RS1_DATA,
    input  logic [XLEN-1:0]    ID_RS2_DATA,
    input  logic [XLEN-1:0]    ID_IMM,
    input  logic               ID_OP1_SEL,
    input  logic               ID_OP2_SEL,
    input  logic [ALUOP_W-1:0] ID_ALU_OPERATION,
    input  logic [REG_AW-1:0]  ID_RD_ADDR,
    input  logic               ID_REG_WRITE,
    input  logic               ID_MEM_READ,
    input  logic               ID_MEM_WRITE,
    input  logic               HOLD,
    input  logic               FLUSH,
    input  logic               EXM_REG_WRITE,
    input  logic [REG_AW-1:0]  EXM_RD_ADDR,
    input  logic [XLEN-1:0]    EXM_RESULT,
    input  logic               MWB_REG_WRITE,
    input  logic [REG_AW-1:0]  MWB_RD_ADDR,
    input  logic [XLEN-1:0]    MWB_RESULT,
    output logic [XLEN-1:0]    DATA1,
    output logic [XLEN-1:0]    DATA2,
    output logic [ALUOP_W-1:0] ALU_OPERATION,
    output logic               EX_VALID,
    output logic               EX_REG_WRITE,
    output logic               EX_MEM_READ,
    output logic               EX_MEM_WRITE,
    output logic [REG_AW-1:0]  EX_RD_ADDR,
    output logic [XLEN-1:0]    EX_STORE_DATA,
    output logic               STALL
);

    typedef struct packed {
        logic               valid;
        logic [XLEN-1:0]    pc;
        logic [REG_AW-1:0]  rs1_addr;
        logic [REG_AW-1:0]  rs2_addr;
        logic [XLEN-1:0]    rs1_data;
        logic [XLEN-1:0]    rs2_data;
        logic [XLEN-1:0]    imm;
        logic               op1_sel;
        logic               op2_sel;
        logic [ALUOP_W-1:0] alu_op;
        logic [REG_AW-1:0]  rd_addr;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
    } stage_t;

    stage_t            r_stage;
    stage_t            w_next;
    logic              w_bubble;
    logic              w_wt_rs1;
    logic              w_wt_rs2;
    logic              w_hit_rs1;
    logic              w_hit_rs2;
    logic [XLEN-1:0]   w_fwd_rs1;
    logic [XLEN-1:0]   w_fwd_rs2;

    // Load-use: the load in EX cannot supply its data to the instruction in ID yet.
    assign w_hit_rs1 = ID_USES_RS1 && (ID_RS1_ADDR == r_stage.rd_addr);
    assign w_hit_rs2 = ID_USES_RS2 && (ID_RS2_ADDR == r_stage.rd_addr);
    assign STALL = r_stage.valid && r_stage.mem_read && (r_stage.rd_addr != '0)
                   && (w_hit_rs1 || w_hit_rs2) && ID_VALID && !FLUSH;

    // Register file writes in the same cycle it is read are captured directly.
    assign w_wt_rs1 = MWB_REG_WRITE && (MWB_RD_ADDR != '0) && (MWB_RD_ADDR == ID_RS1_ADDR);
    assign w_wt_rs2 = MWB_REG_WRITE && (MWB_RD_ADDR != '0) && (MWB_RD_ADDR == ID_RS2_ADDR);

    assign w_bubble = FLUSH || STALL;

    always_comb begin
        w_next = '0;
        if (!w_bubble) begin
            w_next.valid     = ID_VALID;
            w_next.pc        = ID_PC;
            w_next.rs1_addr  = ID_RS1_ADDR;
            w_next.rs2_addr  = ID_RS2_ADDR;
            w_next.rs1_data  = w_wt_rs1 ? MWB_RESULT : ID_RS1_DATA;
            w_next.rs2_data  = w_wt_rs2 ? MWB_RESULT : ID_RS2_DATA;
            w_next.imm       = ID_IMM;
            w_next.op1_sel   = ID_OP1_SEL;
            w_next.op2_sel   = ID_OP2_SEL;
            w_next.alu_op    = ID_ALU_OPERATION;
            w_next.rd_addr   = ID_RD_ADDR;
            w_next.reg_write = ID_VALID && ID_REG_WRITE;
            w_next.mem_read  = ID_VALID && ID_MEM_READ;
            w_next.mem_write = ID_VALID && ID_MEM_WRITE;
        end
    end

    // FLUSH overrides HOLD; a stall under HOLD freezes instead of bubbling.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_stage <= '0;
        end else if (FLUSH || !HOLD) begin
            r_stage <= w_next;
        end
    end

    // EX/MEM is the younger producer, so it wins over MEM/WB; x0 never forwards.
    always_comb begin
        w_fwd_rs1 = r_stage.rs1_data;
        if (EXM_REG_WRITE && (EXM_RD_ADDR != '0) && (EXM_RD_ADDR == r_stage.rs1_addr))
            w_fwd_rs1 = EXM_RESULT;
        else if (MWB_REG_WRITE && (MWB_RD_ADDR != '0) && (MWB_RD_ADDR == r_stage.rs1_addr))
            w_fwd_rs1 = MWB_RESULT;

        w_fwd_rs2 = r_stage.rs2_data;
        if (EXM_REG_WRITE && (EXM_RD_ADDR != '0) && (EXM_RD_ADDR == r_stage.rs2_addr))
            w_fwd_rs2 = EXM_RESULT;
        else if (MWB_REG_WRITE && (MWB_RD_ADDR != '0) && (MWB_RD_ADDR == r_stage.rs2_addr))
            w_fwd_rs2 = MWB_RESULT;
    end

    assign DATA1         = r_stage.op1_sel ? r_stage.pc  : w_fwd_rs1;
    assign DATA2         = r_stage.op2_sel ? r_stage.imm : w_fwd_rs2;
    assign EX_STORE_DATA = w_fwd_rs2;
    assign ALU_OPERATION = r_stage.alu_op;
    assign EX_VALID      = r_stage.valid;
    assign EX_REG_WRITE  = r_stage.reg_write;
    assign EX_MEM_READ   = r_stage.mem_read;
    assign EX_MEM_WRITE  = r_stage.mem_write;
    assign EX_RD_ADDR    = r_stage.rd_addr;

endmodule
